// File: rtl/op_share_arbiter.sv
// op_share_arbiter: round-robin share of one single-operand operator between num_ch req/ack channels
//   clk, rst           : rising-edge clock, asynchronous active-low reset
//   req_l, ack_l, din  : per-channel operand request, producer ack pulse, operand slices
//   req_r, ack_r, dout : per-channel result demand, result ack pulse, shared result bus
//   grant, busy, served: selected channel, not idle, completed delivery count
module op_share_arbiter #(
   parameter int data_width = 32,
   parameter int num_ch = 4,
   parameter string op = "addi",
   parameter logic [data_width-1:0] immediate = '0,
   localparam int gw = num_ch > 1 ? $clog2(num_ch) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [num_ch-1:0]            req_l,
   input  logic [num_ch-1:0]            ack_l,
   input  logic [data_width*num_ch-1:0] din,
   input  logic [num_ch-1:0]            req_r,
   output logic [num_ch-1:0]            ack_r,
   output logic [data_width-1:0]        dout,
   output logic [gw-1:0]                grant,
   output logic                         busy,
   output logic [31:0]                  served
);
   localparam int opc = op == "addi" ? 0 : op == "subi" ? 1 : op == "muli" ? 2 : 3;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DELIVER} state_t;
   state_t state, state_n;
   logic [gw-1:0] ptr, pick, idx, ptr_n;
   logic [data_width-1:0] operand, result, f_out;
   logic [data_width-1:0] slot [num_ch];
   logic [num_ch-1:0] one_pick, one_grant;
   logic start, cap, run, give;
   for (genvar i = 0; i < num_ch; i++) begin : g_slot
      assign slot[i] = din[i*data_width +: data_width];
   end
   assign one_pick = num_ch'(1) << pick;
   assign one_grant = num_ch'(1) << grant;
   assign ptr_n = int'(grant) == num_ch - 1 ? '0 : grant + 1'b1;
   assign busy = state != IDLE;
   // scan downward so the requester closest after ptr (cyclically) wins
   always_comb begin
      pick = ptr;
      idx = '0;
      for (int k = num_ch - 1; k >= 0; k--) begin
         idx = gw'((int'(ptr) + k) % num_ch);
         if (req_r[idx]) pick = idx;
      end
   end
   always_comb f_out = opc == 0 ? operand + immediate :
                       opc == 1 ? operand - immediate :
                       opc == 2 ? operand * immediate : operand;
   always_comb begin
      state_n = state;
      start = 1'b0;
      cap = 1'b0;
      run = 1'b0;
      give = 1'b0;
      case (state)
         IDLE: if (|req_r) begin
            start = 1'b1;
            state_n = FETCH;
         end
         FETCH: if (ack_l[grant]) begin
            cap = 1'b1;
            state_n = EXEC;
         end
         EXEC: begin
            run = 1'b1;
            state_n = DELIVER;
         end
         DELIVER: if (req_r[grant] && !ack_r[grant]) begin
            give = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         req_l <= '0;
         ack_r <= '0;
         dout <= '0;
         grant <= '0;
         ptr <= '0;
         served <= '0;
         operand <= '0;
         result <= '0;
      end else begin
         ack_r <= '0;
         if (start) begin
            grant <= pick;
            req_l <= one_pick;
         end
         if (cap) begin
            operand <= slot[grant];
            req_l <= '0;
         end
         if (run) result <= f_out;
         if (give) begin
            ack_r <= one_grant;
            dout <= result;
            served <= served + 32'd1;
            ptr <= ptr_n;
         end
      end
endmodule

// File: tb/tb_op_share_arbiter.sv
// tb_op_share_arbiter: scoreboard bench for op_share_arbiter (addi x4, subi x1, muli x1)
module tb_op_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [3:0] req_l, ack_l, req_r, ack_r, p_ack, m_ack;
   logic [127:0] din, p_din, m_din;
   logic [31:0] dout, served;
   logic [1:0] grant;
   logic busy;
   logic req_r1, ack_l1;
   logic [31:0] din_s, din_m, dout_s, dout_m, served_s, served_m;
   logic req_l_s, ack_r_s, grant_s, busy_s, req_l_m, ack_r_m, grant_m, busy_m;
   logic prod_en = 1'b0;
   int compared = 0;
   int mismatched = 0;
   logic [31:0] exp_q [4][$];
   int del_ch[$];

   always #5 clk = ~clk;
   assign ack_l = prod_en ? p_ack : m_ack;
   assign din = prod_en ? p_din : m_din;

   op_share_arbiter #(.data_width(32), .num_ch(4), .op("addi"), .immediate(32'd2)) u0 (
      .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din), .req_r(req_r),
      .ack_r(ack_r), .dout(dout), .grant(grant), .busy(busy), .served(served));
   op_share_arbiter #(.data_width(32), .num_ch(1), .op("subi"), .immediate(32'd5)) u1 (
      .clk(clk), .rst(rst), .req_l(req_l_s), .ack_l(ack_l1), .din(din_s), .req_r(req_r1),
      .ack_r(ack_r_s), .dout(dout_s), .grant(grant_s), .busy(busy_s), .served(served_s));
   op_share_arbiter #(.data_width(32), .num_ch(1), .op("muli"), .immediate(32'd2)) u2 (
      .clk(clk), .rst(rst), .req_l(req_l_m), .ack_l(ack_l1), .din(din_m), .req_r(req_r1),
      .ack_r(ack_r_m), .dout(dout_m), .grant(grant_m), .busy(busy_m), .served(served_m));

   // producers: ack one cycle after seeing req_l, channel i supplies i, i+4, i+8, ...
   initial begin
      logic [3:0] seen;
      logic [31:0] nv [4];
      seen = '0;
      p_ack = '0;
      p_din = '0;
      for (int i = 0; i < 4; i++) nv[i] = 32'(i);
      forever begin
         @(negedge clk);
         p_ack = '0;
         if (!rst) begin
            seen = '0;
            for (int i = 0; i < 4; i++) nv[i] = 32'(i);
         end else if (prod_en) begin
            for (int i = 0; i < 4; i++)
               if (req_l[i] && seen[i]) begin
                  p_ack[i] = 1'b1;
                  p_din[i*32 +: 32] = nv[i];
                  exp_q[i].push_back(nv[i] + 32'd2);
                  nv[i] = nv[i] + 32'd4;
               end
            seen = req_l;
         end else seen = '0;
      end
   end

   // consumer monitor: every result pulse is popped from its channel's scoreboard queue
   initial begin
      int ch;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (req_l !== 4'b0) begin
            compared++;
            if ($countones(req_l) != 1) begin
               mismatched++;
               $display("FAIL req_l_onehot: got %b, want at most one bit", req_l);
            end
         end
         if (ack_r !== 4'b0) begin
            compared++;
            if ($countones(ack_r) != 1) begin
               mismatched++;
               $display("FAIL ack_r_onehot: got %b, want one bit", ack_r);
            end else begin
               ch = 0;
               for (int i = 0; i < 4; i++) if (ack_r[i]) ch = i;
               del_ch.push_back(ch);
               if (exp_q[ch].size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_result ch%0d: got %h, want none", ch, dout);
               end else begin
                  e = exp_q[ch].pop_front();
                  if (dout !== e) begin
                     mismatched++;
                     $display("FAIL result ch%0d: got %h, want %h", ch, dout, e);
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      compared++; if (req_l !== 4'b0) begin mismatched++; $display("FAIL reset_req_l: got %b, want 0", req_l); end
      compared++; if (ack_r !== 4'b0) begin mismatched++; $display("FAIL reset_ack_r: got %b, want 0", ack_r); end
      compared++; if (dout !== 32'd0) begin mismatched++; $display("FAIL reset_dout: got %h, want 0", dout); end
      compared++; if (grant !== 2'd0) begin mismatched++; $display("FAIL reset_grant: got %0d, want 0", grant); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b, want 0", busy); end
      compared++; if (served !== 32'd0) begin mismatched++; $display("FAIL reset_served: got %0d, want 0", served); end
      compared++; if (busy_s !== 1'b0 || dout_s !== 32'd0) begin mismatched++; $display("FAIL reset_subi: got busy %b dout %h, want 0 0", busy_s, dout_s); end
      rst = 1'b1;
   endtask

   task automatic test_single();
      int lat;
      prod_en = 1'b0;
      m_ack = '0;
      m_din = '0;
      req_r = 4'b0010;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            compared++; if (req_l !== 4'b0010) begin mismatched++; $display("FAIL single_req_l: got %b, want 0010", req_l); end
            compared++; if (grant !== 2'd1) begin mismatched++; $display("FAIL single_grant: got %0d, want 1", grant); end
         end
         if (lat == 2) begin
            m_ack = 4'b0010;
            m_din[63:32] = 32'd10;
            exp_q[1].push_back(32'd12);
         end
         if (lat == 3) m_ack = '0;
      end while (ack_r === 4'b0 && lat < 40);
      req_r = '0;
      compared++; if (lat != 5) begin mismatched++; $display("FAIL single_latency: got %0d, want 5", lat); end
      compared++; if (ack_r !== 4'b0010) begin mismatched++; $display("FAIL single_ack_r: got %b, want 0010", ack_r); end
      compared++; if (dout !== 32'd12) begin mismatched++; $display("FAIL single_dout: got %0d, want 12", dout); end
      compared++; if (served !== 32'd1) begin mismatched++; $display("FAIL single_served: got %0d, want 1", served); end
      @(negedge clk);
      compared++; if (ack_r !== 4'b0) begin mismatched++; $display("FAIL single_pulse: got %b, want 0", ack_r); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_idle: got busy %b, want 0", busy); end
   endtask

   task automatic test_wrap();
      int n;
      req_r1 = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(req_l_s === 1'b1 && req_l_m === 1'b1) && n < 20);
      compared++; if (req_l_s !== 1'b1 || req_l_m !== 1'b1) begin mismatched++; $display("FAIL wrap_req_l: got %b %b, want 1 1", req_l_s, req_l_m); end
      @(negedge clk);
      ack_l1 = 1'b1;
      din_s = 32'd3;
      din_m = 32'h8000_0001;
      @(negedge clk);
      ack_l1 = 1'b0;
      din_s = '0;
      din_m = '0;
      n = 0;
      while (ack_r_s !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      req_r1 = 1'b0;
      compared++; if (ack_r_s !== 1'b1 || ack_r_m !== 1'b1) begin mismatched++; $display("FAIL wrap_ack: got %b %b, want 1 1", ack_r_s, ack_r_m); end
      compared++; if (dout_s !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL wrap_subi: got %h, want fffffffe", dout_s); end
      compared++; if (dout_m !== 32'h0000_0002) begin mismatched++; $display("FAIL wrap_muli: got %h, want 00000002", dout_m); end
      compared++; if (served_s !== 32'd1 || grant_s !== 1'b0) begin mismatched++; $display("FAIL wrap_single_ch: got served %0d grant %0d, want 1 0", served_s, grant_s); end
      @(negedge clk);
      compared++; if (dout_s !== 32'hFFFF_FFFE || ack_r_s !== 1'b0) begin mismatched++; $display("FAIL wrap_hold: got %h ack %b, want fffffffe 0", dout_s, ack_r_s); end
   endtask

   task automatic test_fairness();
      int n, bad;
      int cnt [4];
      do_reset();
      del_ch.delete();
      prod_en = 1'b1;
      req_r = 4'b1111;
      n = 0;
      while (served !== 32'd400 && n < 3000) begin @(negedge clk); n++; end
      req_r = '0;
      compared++; if (served !== 32'd400) begin mismatched++; $display("FAIL rr_served: got %0d, want 400", served); end
      repeat (3) @(negedge clk);
      compared++; if (del_ch.size() != 400) begin mismatched++; $display("FAIL rr_deliveries: got %0d, want 400", del_ch.size()); end
      bad = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      foreach (del_ch[k]) begin
         if (del_ch[k] != k % 4) bad++;
         cnt[del_ch[k]]++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL rr_order: got %0d out-of-turn grants, want 0", bad); end
      for (int i = 0; i < 4; i++) begin
         compared++; if (cnt[i] != 100) begin mismatched++; $display("FAIL rr_count ch%0d: got %0d, want 100", i, cnt[i]); end
         compared++; if (exp_q[i].size() != 0) begin mismatched++; $display("FAIL rr_pending ch%0d: got %0d, want 0", i, exp_q[i].size()); end
      end
   endtask

   task automatic test_backpressure();
      int n, bad;
      do_reset();
      prod_en = 1'b1;
      req_r = 4'b0100;
      n = 0;
      while (req_l !== 4'b0100 && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (req_l !== 4'b0 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_r = 4'b1011;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b1 || ack_r !== 4'b0 || grant !== 2'd2 || req_l !== 4'b0 || dout !== 32'd0) bad++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL bp_hold: got %0d bad cycles, want 0", bad); end
      req_r = 4'b1111;
      @(negedge clk);
      req_r = '0;
      compared++; if (ack_r !== 4'b0100) begin mismatched++; $display("FAIL bp_ack: got %b, want 0100", ack_r); end
      compared++; if (dout !== 32'd4) begin mismatched++; $display("FAIL bp_dout: got %0d, want 4", dout); end
      compared++; if (served !== 32'd1) begin mismatched++; $display("FAIL bp_served: got %0d, want 1", served); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_spurious();
      do_reset();
      prod_en = 1'b0;
      m_ack = '0;
      m_din = '0;
      req_r = 4'b0001;
      @(negedge clk);
      compared++; if (req_l !== 4'b0001) begin mismatched++; $display("FAIL sp_req_l: got %b, want 0001", req_l); end
      m_ack = 4'b1000;
      m_din = {32'd99, 64'd0, 32'd77};
      @(negedge clk);
      compared++; if (req_l !== 4'b0001) begin mismatched++; $display("FAIL sp_other_ack: got req_l %b, want 0001", req_l); end
      m_ack = 4'b0001;
      m_din = {96'd0, 32'd40};
      exp_q[0].push_back(32'd42);
      @(negedge clk);
      compared++; if (req_l !== 4'b0) begin mismatched++; $display("FAIL sp_capture: got req_l %b, want 0", req_l); end
      m_ack = 4'b0001;
      m_din = {96'd0, 32'd555};
      @(negedge clk);
      m_ack = '0;
      @(negedge clk);
      req_r = '0;
      compared++; if (ack_r !== 4'b0001) begin mismatched++; $display("FAIL sp_ack: got %b, want 0001", ack_r); end
      compared++; if (dout !== 32'd42) begin mismatched++; $display("FAIL sp_dout: got %0d, want 42", dout); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_fetch();
      int n;
      prod_en = 1'b0;
      m_ack = '0;
      req_r = 4'b0100;
      @(negedge clk);
      compared++; if (req_l !== 4'b0100) begin mismatched++; $display("FAIL rf_req_l: got %b, want 0100", req_l); end
      #2 rst = 1'b0;
      #1;
      compared++; if (req_l !== 4'b0) begin mismatched++; $display("FAIL rf_async_req_l: got %b, want 0", req_l); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rf_async_busy: got %b, want 0", busy); end
      compared++; if (served !== 32'd0) begin mismatched++; $display("FAIL rf_async_served: got %0d, want 0", served); end
      compared++; if (grant !== 2'd0) begin mismatched++; $display("FAIL rf_async_grant: got %0d, want 0", grant); end
      req_r = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      prod_en = 1'b1;
      req_r = 4'b1111;
      n = 0;
      do begin @(negedge clk); n++; end while (ack_r === 4'b0 && n < 20);
      req_r = '0;
      compared++; if (ack_r !== 4'b0001) begin mismatched++; $display("FAIL rf_ptr0: got %b, want 0001", ack_r); end
      compared++; if (dout !== 32'd2) begin mismatched++; $display("FAIL rf_dout: got %0d, want 2", dout); end
      compared++; if (served !== 32'd1) begin mismatched++; $display("FAIL rf_served: got %0d, want 1", served); end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      req_r = '0;
      m_ack = '0;
      m_din = '0;
      req_r1 = 1'b0;
      ack_l1 = 1'b0;
      din_s = '0;
      din_m = '0;
      test_reset();
      test_single();
      test_wrap();
      test_fairness();
      test_backpressure();
      test_spurious();
      test_reset_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
